// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding and load-use bubbles.
// Presents registered ALU operands downstream through a valid/ready handshake.
module id_ex_stage #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_pc,
    input  logic [31:0]      in_inst,
    input  logic [XLEN-1:0]  in_rs1_data,
    input  logic [XLEN-1:0]  in_rs2_data,
    input  logic [XLEN-1:0]  in_imm,
    input  logic [3:0]       in_alu_op,
    input  logic             in_alu_src_b,
    input  logic             ex_we,
    input  logic [4:0]       ex_rd,
    input  logic [XLEN-1:0]  ex_res,
    input  logic             ex_is_load,
    input  logic             wb_we,
    input  logic [4:0]       wb_rd,
    input  logic [XLEN-1:0]  wb_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  a,
    output logic [XLEN-1:0]  b,
    output logic [XLEN-1:0]  rs2_fwd,
    output logic [3:0]       alu_op,
    output logic [31:0]      inst,
    output logic [31:0]      pc,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_REG32  = 7'b0111011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    logic             valid_q, valid_d;
    logic [XLEN-1:0]  a_q, a_d;
    logic [XLEN-1:0]  b_q, b_d;
    logic [XLEN-1:0]  rs2f_q, rs2f_d;
    logic [3:0]       op_q, op_d;
    logic [31:0]      inst_q, inst_d;
    logic [31:0]      pc_q, pc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [4:0]      rs1, rs2;
    logic [6:0]      opcode;
    logic            use_rs1, use_rs2;
    logic            hazard, load_en;
    logic [XLEN-1:0] fwd_rs1, fwd_rs2;

    // EX result wins over WB; a load in EX has no data yet so never forwards.
    function automatic logic [XLEN-1:0] fwd(
        input logic [4:0]      s,
        input logic [XLEN-1:0] rf,
        input logic            e_we,
        input logic [4:0]      e_rd,
        input logic [XLEN-1:0] e_res,
        input logic            e_ld,
        input logic            w_we,
        input logic [4:0]      w_rd,
        input logic [XLEN-1:0] w_dat
    );
        logic [XLEN-1:0] r;
        if (s == 5'd0)
            r = '0;
        else if (e_we && e_rd == s && !e_ld)
            r = e_res;
        else if (w_we && w_rd == s)
            r = w_dat;
        else
            r = rf;
        return r;
    endfunction

    // Decode source usage, forward operands and detect load-use hazards.
    always_comb begin
        opcode  = in_inst[6:0];
        rs1     = in_inst[19:15];
        rs2     = in_inst[24:20];
        use_rs1 = !(opcode == OP_LUI || opcode == OP_AUIPC || opcode == OP_JAL);
        use_rs2 = (opcode == OP_REG) || (opcode == OP_REG32) ||
                  (opcode == OP_STORE) || (opcode == OP_BRANCH);
        fwd_rs1 = fwd(rs1, in_rs1_data, ex_we, ex_rd, ex_res, ex_is_load,
                      wb_we, wb_rd, wb_data);
        fwd_rs2 = fwd(rs2, in_rs2_data, ex_we, ex_rd, ex_res, ex_is_load,
                      wb_we, wb_rd, wb_data);
        hazard  = in_valid && ex_we && ex_is_load && (ex_rd != 5'd0) &&
                  ((use_rs1 && ex_rd == rs1) || (use_rs2 && ex_rd == rs2));
        load_en  = !valid_q || out_ready;
        in_ready = rstn && load_en && !hazard && !flush;
    end

    // Next-state for the pipeline register and the saturating stall counter.
    always_comb begin
        valid_d = valid_q;
        a_d     = a_q;
        b_d     = b_q;
        rs2f_d  = rs2f_q;
        op_d    = op_q;
        inst_d  = inst_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (load_en && in_valid && in_ready) begin
            valid_d = 1'b1;
            a_d     = fwd_rs1;
            b_d     = in_alu_src_b ? in_imm : fwd_rs2;
            rs2f_d  = fwd_rs2;
            op_d    = in_alu_op;
            inst_d  = in_inst;
            pc_d    = in_pc;
        end else if (load_en) begin
            valid_d = 1'b0;
        end
        if (load_en && hazard && !flush && cnt_q != {CNT_W{1'b1}})
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            valid_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            rs2f_q  <= '0;
            op_q    <= '0;
            inst_q  <= '0;
            pc_q    <= '0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            a_q     <= a_d;
            b_q     <= b_d;
            rs2f_q  <= rs2f_d;
            op_q    <= op_d;
            inst_q  <= inst_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out_valid = valid_q;
    assign a         = a_q;
    assign b         = b_q;
    assign rs2_fwd   = rs2f_q;
    assign alu_op    = op_q;
    assign inst      = inst_q;
    assign pc        = pc_q;
    assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed testbench for id_ex_stage.
// Small stall counter width so saturation is reachable.
module tb_id_ex_stage;

    localparam int XLEN  = 64;
    localparam int CNT_W = 3;

    localparam logic [31:0] I_ADD  = 32'h002081B3; // add x3,x1,x2
    localparam logic [31:0] I_ADDI = 32'h00700293; // addi x5,x0,7
    localparam logic [31:0] I_SUB  = 32'h40208233; // sub x4,x1,x2
    localparam logic [31:0] I_LUI  = 32'h00010337; // lui x6,0x10 (rs1 field = 2)

    logic             clk = 1'b0;
    logic             rstn;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_pc;
    logic [31:0]      in_inst;
    logic [XLEN-1:0]  in_rs1_data;
    logic [XLEN-1:0]  in_rs2_data;
    logic [XLEN-1:0]  in_imm;
    logic [3:0]       in_alu_op;
    logic             in_alu_src_b;
    logic             ex_we;
    logic [4:0]       ex_rd;
    logic [XLEN-1:0]  ex_res;
    logic             ex_is_load;
    logic             wb_we;
    logic [4:0]       wb_rd;
    logic [XLEN-1:0]  wb_data;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  a;
    logic [XLEN-1:0]  b;
    logic [XLEN-1:0]  rs2_fwd;
    logic [3:0]       alu_op;
    logic [31:0]      inst;
    logic [31:0]      pc;
    logic [CNT_W-1:0] stall_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    id_ex_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk(clk), .rstn(rstn), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_inst(in_inst),
        .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
        .in_imm(in_imm), .in_alu_op(in_alu_op), .in_alu_src_b(in_alu_src_b),
        .ex_we(ex_we), .ex_rd(ex_rd), .ex_res(ex_res), .ex_is_load(ex_is_load),
        .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .a(a), .b(b), .rs2_fwd(rs2_fwd), .alu_op(alu_op),
        .inst(inst), .pc(pc), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic v, input logic [31:0] p,
                         input logic [31:0] i, input logic [XLEN-1:0] r1,
                         input logic [XLEN-1:0] r2, input logic [XLEN-1:0] im,
                         input logic [3:0] op, input logic sb);
        in_valid = v; in_pc = p; in_inst = i;
        in_rs1_data = r1; in_rs2_data = r2; in_imm = im;
        in_alu_op = op; in_alu_src_b = sb;
    endtask

    task automatic clear_fwd();
        ex_we = 1'b0; ex_rd = 5'd0; ex_res = '0; ex_is_load = 1'b0;
        wb_we = 1'b0; wb_rd = 5'd0; wb_data = '0;
    endtask

    task automatic test_reset();
        rstn = 1'b0; flush = 1'b0; out_ready = 1'b1;
        clear_fwd();
        drive(1'b1, 32'h100, I_ADD, 64'd1, 64'd2, 64'd0, 4'd0, 1'b0);
        @(negedge clk); #1;
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++; $display("FAIL reset_in_ready: got %b want 0", in_ready);
        end
        @(negedge clk); #1;
        n_checks++;
        if (out_valid !== 1'b0 || a !== '0 || b !== '0) begin
            n_fail++;
            $display("FAIL reset_out: got v=%b a=%h b=%h want 0/0/0", out_valid, a, b);
        end
        n_checks++;
        if (stall_cnt !== '0 || inst !== '0 || pc !== '0 || alu_op !== '0 || rs2_fwd !== '0) begin
            n_fail++;
            $display("FAIL reset_regs: got cnt=%0d inst=%h pc=%h op=%h r2=%h want zeros",
                     stall_cnt, inst, pc, alu_op, rs2_fwd);
        end
    endtask

    task automatic test_ex_forward();
        @(negedge clk);
        rstn = 1'b1;
        drive(1'b1, 32'h200, I_ADD, 64'd5, 64'd3, 64'd0, 4'd1, 1'b0);
        ex_we = 1'b1; ex_rd = 5'd1; ex_res = 64'h10;
        wb_we = 1'b1; wb_rd = 5'd1; wb_data = 64'h20;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL exfwd_in_ready: got %b want 1", in_ready);
        end
        @(posedge clk); #1;
        n_checks++;
        if (out_valid !== 1'b1 || a !== 64'h10 || b !== 64'd3) begin
            n_fail++;
            $display("FAIL exfwd_out: got v=%b a=%h b=%h want 1/10/3", out_valid, a, b);
        end
        n_checks++;
        if (inst !== I_ADD || pc !== 32'h200 || alu_op !== 4'd1) begin
            n_fail++;
            $display("FAIL exfwd_payload: got inst=%h pc=%h op=%h want %h/200/1",
                     inst, pc, alu_op, I_ADD);
        end
        @(negedge clk);
        ex_we = 1'b0;
        in_pc = 32'h204;
        @(posedge clk); #1;
        n_checks++;
        if (a !== 64'h20 || pc !== 32'h204) begin
            n_fail++; $display("FAIL wbfwd_a: got a=%h pc=%h want 20/204", a, pc);
        end
    endtask

    task automatic test_x0_imm();
        @(negedge clk);
        clear_fwd();
        drive(1'b1, 32'h300, I_ADDI, 64'h55, 64'hAB, 64'd7, 4'd2, 1'b1);
        ex_we = 1'b1; ex_rd = 5'd0; ex_res = 64'hFF;
        @(posedge clk); #1;
        n_checks++;
        if (out_valid !== 1'b1 || a !== 64'd0 || b !== 64'd7) begin
            n_fail++;
            $display("FAIL x0imm_ab: got v=%b a=%h b=%h want 1/0/7", out_valid, a, b);
        end
        n_checks++;
        if (rs2_fwd !== 64'hAB) begin
            n_fail++; $display("FAIL x0imm_rs2fwd: got %h want ab", rs2_fwd);
        end
    endtask

    task automatic test_load_use();
        @(negedge clk);
        clear_fwd();
        drive(1'b1, 32'h400, I_SUB, 64'd1, 64'd2, 64'd0, 4'd3, 1'b0);
        ex_we = 1'b1; ex_rd = 5'd2; ex_is_load = 1'b1; ex_res = 64'hDEAD;
        #1;
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++; $display("FAIL lu_in_ready: got %b want 0", in_ready);
        end
        @(posedge clk); #1;
        n_checks++;
        if (out_valid !== 1'b0 || stall_cnt !== 3'd1) begin
            n_fail++;
            $display("FAIL lu_bubble: got v=%b cnt=%0d want 0/1", out_valid, stall_cnt);
        end
        n_checks++;
        if (a !== 64'd0 || inst !== I_ADDI) begin
            n_fail++;
            $display("FAIL lu_hold_payload: got a=%h inst=%h want 0/%h", a, inst, I_ADDI);
        end
        @(negedge clk);
        clear_fwd();
        wb_we = 1'b1; wb_rd = 5'd2; wb_data = 64'h99;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL lu_resume_ready: got %b want 1", in_ready);
        end
        @(posedge clk); #1;
        n_checks++;
        if (out_valid !== 1'b1 || a !== 64'd1 || b !== 64'h99 || rs2_fwd !== 64'h99) begin
            n_fail++;
            $display("FAIL lu_resume: got v=%b a=%h b=%h r2=%h want 1/1/99/99",
                     out_valid, a, b, rs2_fwd);
        end
        n_checks++;
        if (stall_cnt !== 3'd1 || inst !== I_SUB) begin
            n_fail++;
            $display("FAIL lu_resume_cnt: got cnt=%0d inst=%h want 1/%h", stall_cnt, inst, I_SUB);
        end
    endtask

    task automatic test_unused_src();
        @(negedge clk);
        clear_fwd();
        drive(1'b1, 32'h500, I_LUI, 64'h77, 64'h0, 64'h10000, 4'd4, 1'b1);
        ex_we = 1'b1; ex_rd = 5'd2; ex_is_load = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL lui_no_hazard: got in_ready=%b want 1", in_ready);
        end
        @(posedge clk); #1;
        n_checks++;
        if (out_valid !== 1'b1 || a !== 64'h77 || b !== 64'h10000 || stall_cnt !== 3'd1) begin
            n_fail++;
            $display("FAIL lui_out: got v=%b a=%h b=%h cnt=%0d want 1/77/10000/1",
                     out_valid, a, b, stall_cnt);
        end
    endtask

    task automatic test_backpressure();
        @(negedge clk);
        clear_fwd();
        out_ready = 1'b0;
        drive(1'b1, 32'h600, I_ADD, 64'h111, 64'h222, 64'd0, 4'd5, 1'b0);
        for (int k = 0; k < 3; k++) begin
            #1;
            n_checks++;
            if (in_ready !== 1'b0) begin
                n_fail++; $display("FAIL bp_in_ready[%0d]: got %b want 0", k, in_ready);
            end
            @(posedge clk); #1;
            n_checks++;
            if (out_valid !== 1'b1 || a !== 64'h77 || b !== 64'h10000 || inst !== I_LUI) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: got v=%b a=%h b=%h inst=%h want 1/77/10000/%h",
                         k, out_valid, a, b, inst, I_LUI);
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL bp_release_ready: got %b want 1", in_ready);
        end
        @(posedge clk); #1;
        n_checks++;
        if (out_valid !== 1'b1 || a !== 64'h111 || b !== 64'h222 || inst !== I_ADD || pc !== 32'h600) begin
            n_fail++;
            $display("FAIL bp_release: got v=%b a=%h b=%h inst=%h pc=%h want 1/111/222/%h/600",
                     out_valid, a, b, inst, pc, I_ADD);
        end
    endtask

    task automatic test_flush();
        @(negedge clk);
        out_ready = 1'b0;
        flush = 1'b1;
        drive(1'b1, 32'h700, I_SUB, 64'h3, 64'h4, 64'd0, 4'd6, 1'b0);
        #1;
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++; $display("FAIL flush_in_ready: got %b want 0", in_ready);
        end
        @(posedge clk); #1;
        n_checks++;
        if (out_valid !== 1'b0 || inst !== I_ADD || a !== 64'h111) begin
            n_fail++;
            $display("FAIL flush_out: got v=%b inst=%h a=%h want 0/%h/111",
                     out_valid, inst, a, I_ADD);
        end
        @(negedge clk);
        flush = 1'b0;
        in_valid = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL flush_idle: got v=%b want 0", out_valid);
        end
    endtask

    task automatic test_stall_cnt();
        logic [CNT_W-1:0] exp;
        @(negedge clk);
        out_ready = 1'b1;
        flush = 1'b1;
        drive(1'b1, 32'h800, I_SUB, 64'd1, 64'd2, 64'd0, 4'd3, 1'b0);
        ex_we = 1'b1; ex_rd = 5'd1; ex_is_load = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (stall_cnt !== 3'd1) begin
            n_fail++; $display("FAIL cnt_flush: got %0d want 1", stall_cnt);
        end
        @(negedge clk);
        flush = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            exp = (k + 1 > 7) ? 3'd7 : 3'(k + 1);
            @(posedge clk); #1;
            n_checks++;
            if (stall_cnt !== exp || out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL cnt_sat[%0d]: got cnt=%0d v=%b want %0d/0",
                         k, stall_cnt, out_valid, exp);
            end
        end
        @(negedge clk);
        clear_fwd();
        in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_ex_forward();
        test_x0_imm();
        test_load_use();
        test_unused_src();
        test_backpressure();
        test_flush();
        test_stall_cnt();
        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish within bound");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Pipeline register and operand-select stage directly upstream of the ALU in the pipelined RV64 core.
- Accepts decoded instructions from ID and resolves rs1/rs2 via EX/MEM and MEM/WB forwarding.
- Selects immediate vs register for operand b, then presents registered operands `a`/`b`, `alu_op`, `inst` and `pc` to the ALU with a valid/ready handshake.
- Detects load-use hazards and inserts bubbles.

Parameters:
- XLEN, 64, datapath width of operands and forwarded results.
- CNT_W, 32, width of the saturating stall counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rstn  in  1  reset, synchronous, active-low.
- flush  in  1  branch/jump redirect; kill the held and the incoming instruction.
- in_valid  in  1  ID presents an instruction.
- in_ready  out  1  stage accepts the ID instruction this cycle.
- in_pc  in  32  instruction PC.
- in_inst  in  32  raw instruction; rs1=[19:15], rs2=[24:20], opcode=[6:0].
- in_rs1_data  in  XLEN  register-file read of rs1.
- in_rs2_data  in  XLEN  register-file read of rs2.
- in_imm  in  XLEN  sign-extended immediate.
- in_alu_op  in  4  ALU op code.
- in_alu_src_b  in  1  1 = b takes imm, 0 = b takes forwarded rs2.
- ex_we  in  1  EX/MEM writes rd.
- ex_rd  in  5  EX/MEM destination.
- ex_res  in  XLEN  EX/MEM result.
- ex_is_load  in  1  EX/MEM instruction is a load; data not yet available.
- wb_we  in  1  MEM/WB writes rd.
- wb_rd  in  5  MEM/WB destination.
- wb_data  in  XLEN  MEM/WB write data.
- out_valid  out  1  ALU-side operands valid.
- out_ready  in  1  ALU side consumes this cycle.
- a  out  XLEN  ALU operand a (forwarded rs1).
- b  out  XLEN  ALU operand b.
- rs2_fwd  out  XLEN  forwarded rs2, used as store data.
- alu_op  out  4  registered alu op.
- inst  out  32  registered instruction.
- pc  out  32  registered PC.
- stall_cnt  out  CNT_W  number of load-use bubbles inserted; saturating.

Behaviour:
- Reset (rstn=0 at a clock edge):
  - out_valid, a, b, rs2_fwd, alu_op, inst, pc and stall_cnt all go to 0.
  - in_ready is 0 for the whole cycle in which rstn=0.
- Operand use by opcode:
  - rs1 is used unless the opcode is 0110111 (lui), 0010111 (auipc) or 1101111 (jal).
  - rs2 is used only for opcodes 0110011, 0111011, 0100011 and 1100011.
- Forwarding (combinational, per source, index s):
  - s==0 → 0.
  - else if ex_we && ex_rd==s && !ex_is_load → ex_res.
  - else if wb_we && wb_rd==s → wb_data.
  - else → register-file data.
  - EX has priority over WB.
- Hazard: `hazard` = in_valid && ex_we && ex_is_load && ex_rd!=0 && (ex_rd matches a used rs1 or a used rs2).
- Handshake:
  - load_en = !out_valid || out_ready.
  - in_ready = load_en && !hazard && !flush.
  - Latency from ID acceptance to ALU presentation is one cycle.
- Register update, in priority order:
  - flush → out_valid<=0; no ID transfer occurs.
  - else load_en && in_valid && in_ready → capture all fields; out_valid<=1.
    - a = fwd(rs1).
    - b = in_alu_src_b ? in_imm : fwd(rs2).
    - rs2_fwd = fwd(rs2).
  - else load_en → out_valid<=0 (bubble); payload registers hold their old values.
  - else (out_valid && !out_ready) → hold everything, including a/b.
- Stall counter: increments by 1 on every cycle where load_en && hazard && !flush; it saturates at all ones.
- Downstream contract while holding: producers do not retire while this stage holds, so held operands never go stale. No re-forwarding is done during a hold.
- A hazard persists until the load leaves EX/MEM; the next cycle normally forwards the load result from WB.

Test Plan:
- Reset: hold rstn=0 for 2 cycles with in_valid=1 → out_valid=0, a=b=0, stall_cnt=0, in_ready=0.
- EX forward: inst add x3,x1,x2; in_rs1_data=5; ex_we=1, ex_rd=1, ex_res=0x10; wb_we=1, wb_rd=1, wb_data=0x20 → next cycle a=0x10, out_valid=1.
- x0 and immediate: addi x5,x0,7 with ex_rd=0, ex_we=1, ex_res=0xFF, in_imm=7, alu_src_b=1 → a=0, b=7.
- Load-use: ex_is_load=1, ex_rd=2; incoming sub using rs2=x2 → in_ready=0, bubble (out_valid=0) and stall_cnt=1. Next cycle the load moves to WB with wb_data=0x99 → b=0x99 accepted.
- Backpressure: out_valid=1, out_ready=0 for 3 cycles with new ID input → in_ready=0 and a/b/inst stable. After out_ready=1 the new instruction is captured.
- Flush: flush=1 while out_valid=1 and in_valid=1 → next cycle out_valid=0 and the ID instruction is not accepted (in_ready=0).
